joy_dir_arbiter: RTL and testbench

- Parametrised multi-player joystick direction conditioner for arcade cores. It sits between the keyboard/gamepad merge logic and the core's input ports.
- Per player, it rotates raw directions for screen orientation, debounces them on a clock-enable, then arbitrates them under a selectable mode: 4-way last-pressed with fallback, 4-way first-pressed, 8-way opposite-cancel, or raw.
- It generalises the single 4-way last-pressed filter to N players, four modes, rotation and debounce.

---
 rtl/joy_dir_arbiter.sv | 142 ++++++++++++++
 tb/tb_joy_dir_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/joy_dir_arbiter.sv
// Multi-player joystick direction conditioner: rotation, optional debounce and
// per-player 4-way/8-way arbitration. Bit order per player is {up,down,left,right}.
module joy_dir_arbiter #(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned DEB_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [1:0]             rotate,
  input  logic [2*PLAYERS-1:0]   mode,
  input  logic [4*PLAYERS-1:0]   dir_in,
  output logic [4*PLAYERS-1:0]   dir_out,
  output logic [PLAYERS-1:0]     changed
);

  localparam int unsigned CW = (DEB_CYCLES == 0) ? 1 : $clog2(DEB_CYCLES + 1);

  // Screen-orientation remap of one player's {up,down,left,right}.
  function automatic logic [3:0] rot_map(input logic [1:0] r, input logic [3:0] d);
    case (r)
      2'd1:    rot_map = {d[1], d[0], d[2], d[3]};
      2'd2:    rot_map = {d[2], d[3], d[0], d[1]};
      2'd3:    rot_map = {d[0], d[1], d[3], d[2]};
      default: rot_map = d;
    endcase
  endfunction

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]      raw_q, deb_q, prev_q, out_q, act_q;
    logic            chg_q;
    logic [3:0][1:0] rec_q, rec_nxt;
    logic [3:0]      rise, first_oh, out_nxt, act_nxt;
    logic [1:0]      win, pos, m;

    assign m = mode[2*p +: 2];

    always_ff @(posedge clk) begin
      if (reset) raw_q <= '0;
      else       raw_q <= rot_map(rotate, dir_in[4*p +: 4]);
    end

    if (DEB_CYCLES == 0) begin : g_nodeb
      logic unused_ce;
      assign unused_ce = ce;

      always_ff @(posedge clk) begin
        if (reset) deb_q <= '0;
        else       deb_q <= raw_q;
      end
    end else begin : g_deb
      logic [3:0][CW-1:0] cnt_q;

      // A bit is accepted only after DEB_CYCLES consecutive ce ticks of disagreement.
      always_ff @(posedge clk) begin
        if (reset) begin
          deb_q <= '0;
          cnt_q <= '0;
        end else if (ce) begin
          for (int b = 0; b < 4; b++) begin
            if (raw_q[b] != deb_q[b]) begin
              if (cnt_q[b] == CW'(DEB_CYCLES - 1)) begin
                deb_q[b] <= raw_q[b];
                cnt_q[b] <= '0;
              end else begin
                cnt_q[b] <= cnt_q[b] + CW'(1);
              end
            end else begin
              cnt_q[b] <= '0;
            end
          end
        end
      end
    end

    // Recency update: the highest-priority new press moves to slot 0, others shift down.
    always_comb begin
      rise     = deb_q & ~prev_q;
      win      = 2'd0;
      pos      = 2'd0;
      rec_nxt  = rec_q;
      first_oh = '0;
      out_nxt  = '0;
      act_nxt  = '0;

      if      (rise[3]) win = 2'd0;
      else if (rise[2]) win = 2'd1;
      else if (rise[1]) win = 2'd2;
      else              win = 2'd3;

      for (int i = 0; i < 4; i++) begin
        if (rec_q[i] == win) pos = 2'(i);
      end

      if (rise != 4'b0000) begin
        rec_nxt[0] = win;
        for (int i = 1; i < 4; i++) begin
          if (2'(i) <= pos) rec_nxt[i] = rec_q[i-1];
        end
      end

      for (int i = 3; i >= 0; i--) begin
        if (|(deb_q & (4'b1000 >> rec_nxt[i]))) first_oh = 4'b1000 >> rec_nxt[i];
      end

      act_nxt = first_oh;
      case (m)
        2'd0: out_nxt = first_oh;
        2'd1: begin
          if (|(act_q & deb_q)) act_nxt = act_q;
          out_nxt = act_nxt;
        end
        2'd2: begin
          out_nxt = deb_q;
          if (deb_q[3] && deb_q[2]) out_nxt[3:2] = 2'b00;
          if (deb_q[1] && deb_q[0]) out_nxt[1:0] = 2'b00;
        end
        default: out_nxt = deb_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        prev_q <= '0;
        rec_q  <= {2'd3, 2'd2, 2'd1, 2'd0};
        act_q  <= '0;
        out_q  <= '0;
        chg_q  <= 1'b0;
      end else begin
        prev_q <= deb_q;
        rec_q  <= rec_nxt;
        act_q  <= act_nxt;
        out_q  <= out_nxt;
        chg_q  <= (out_nxt != out_q);
      end
    end

    assign dir_out[4*p +: 4] = out_q;
    assign changed[p]        = chg_q;
  end

endmodule

// File: tb/tb_joy_dir_arbiter.sv
// Bench for joy_dir_arbiter: a debounce-bypassed and a DEB_CYCLES=4 instance are
// driven with directed and random stimulus and compared against a queue-based model.
module tb_joy_dir_arbiter;

  logic       clk = 1'b0;
  logic       reset, ce;
  logic [1:0] rotate;
  logic [3:0] mode;
  logic [7:0] dir_in;
  logic [7:0] dout0, dout4;
  logic [1:0] chg0, chg4;

  always #5 clk = ~clk;

  joy_dir_arbiter #(.PLAYERS(2), .DEB_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .rotate(rotate), .mode(mode),
    .dir_in(dir_in), .dir_out(dout0), .changed(chg0)
  );

  joy_dir_arbiter #(.PLAYERS(2), .DEB_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .ce(ce), .rotate(rotate), .mode(mode),
    .dir_in(dir_in), .dir_out(dout4), .changed(chg4)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state indexed [instance][player]; instance 0 = no debounce, 1 = DEB 4.
  logic [3:0] ma[2][2], mdeb[2][2], mprev[2][2], mout[2][2], mact[2][2];
  logic       mchg[2][2];
  int         mcnt[2][2][4];
  int         mrec[2][2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Direction indices: 0 up, 1 down, 2 left, 3 right; bit position is 3-index.
  function automatic logic [3:0] rot_m(input logic [1:0] r, input logic [3:0] dv);
    logic [7:0] t;
    logic [3:0] o;
    int s;
    case (r)
      2'd1:    t = 8'b10_11_01_00;
      2'd2:    t = 8'b01_00_11_10;
      2'd3:    t = 8'b11_10_00_01;
      default: t = 8'b00_01_10_11;
    endcase
    for (int oi = 0; oi < 4; oi++) begin
      s = int'(t[7-2*oi -: 2]);
      o[3-oi] = dv[3-s];
    end
    return o;
  endfunction

  task automatic step(input int d, input int p);
    logic [3:0] nd, rise, first, nout, nact, cur;
    int q[$];
    int k, pos, dn;
    bit found;
    if (reset) begin
      ma[d][p] = '0; mdeb[d][p] = '0; mprev[d][p] = '0;
      mout[d][p] = '0; mact[d][p] = '0; mchg[d][p] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        mcnt[d][p][i] = 0;
        mrec[d][p][i] = i;
      end
      return;
    end
    dn = (d == 0) ? 0 : 4;
    nd = mdeb[d][p];
    if (dn == 0) nd = ma[d][p];
    else if (ce) begin
      for (int b = 0; b < 4; b++) begin
        if (ma[d][p][b] != mdeb[d][p][b]) begin
          mcnt[d][p][b]++;
          if (mcnt[d][p][b] == dn) begin
            nd[b] = ma[d][p][b];
            mcnt[d][p][b] = 0;
          end
        end else mcnt[d][p][b] = 0;
      end
    end
    cur  = mdeb[d][p];
    rise = cur & ~mprev[d][p];
    for (int i = 0; i < 4; i++) q.push_back(mrec[d][p][i]);
    if (rise != 4'b0000) begin
      k = 0; found = 0;
      for (int i = 0; i < 4; i++)
        if (!found && rise[3-i]) begin k = i; found = 1; end
      pos = 0;
      for (int i = 0; i < 4; i++) if (q[i] == k) pos = i;
      q.delete(pos);
      q.push_front(k);
    end
    first = '0; found = 0;
    for (int i = 0; i < 4; i++)
      if (!found && cur[3-q[i]]) begin first = 4'b0001 << (3 - q[i]); found = 1; end
    nact = first;
    case (mode[2*p +: 2])
      2'd0: nout = first;
      2'd1: begin
        if (mact[d][p] != 0 && (mact[d][p] & cur) != 0) nact = mact[d][p];
        nout = nact;
      end
      2'd2: begin
        nout = cur;
        if (cur[3] && cur[2]) nout[3:2] = 2'b00;
        if (cur[1] && cur[0]) nout[1:0] = 2'b00;
      end
      default: nout = cur;
    endcase
    mchg[d][p]  = (nout != mout[d][p]);
    mout[d][p]  = nout;
    mact[d][p]  = nact;
    mprev[d][p] = cur;
    mdeb[d][p]  = nd;
    ma[d][p]    = rot_m(rotate, dir_in[4*p +: 4]);
    for (int i = 0; i < 4; i++) mrec[d][p][i] = q[i];
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) step(d, p);
    #1;
    check("dout_nodeb", 32'(dout0), 32'({mout[0][1], mout[0][0]}));
    check("chg_nodeb",  32'(chg0),  32'({mchg[0][1], mchg[0][0]}));
    check("dout_deb4",  32'(dout4), 32'({mout[1][1], mout[1][0]}));
    check("chg_deb4",   32'(chg4),  32'({mchg[1][1], mchg[1][0]}));
    cyc++;
    ce = (cyc % 4 == 3);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; rotate = 2'd0; mode = 4'd0; dir_in = 8'd0;
    run(3);
    check("rst_dout", 32'(dout0), 32'h0);
    check("rst_chg",  32'(chg0),  32'h0);
    reset = 1'b0;

    // Mode 0: last-pressed with fallback
    dir_in[3:0] = 4'b0001; run(3);
    check("m0_right", 32'(dout0[3:0]), 32'h1);
    check("m0_right_chg", 32'(chg0[0]), 32'h1);
    run(2);
    dir_in[3:0] = 4'b1001; run(3);
    check("m0_up", 32'(dout0[3:0]), 32'h8);
    dir_in[3:0] = 4'b0001; run(3);
    check("m0_fallback", 32'(dout0[3:0]), 32'h1);
    run(1);
    check("m0_chg_once", 32'(chg0[0]), 32'h0);

    // Mode 1: first-pressed
    dir_in[3:0] = 4'b0000; mode[1:0] = 2'd1; run(4);
    dir_in[3:0] = 4'b0010; run(4);
    dir_in[3:0] = 4'b0110; run(4);
    check("m1_keep_left", 32'(dout0[3:0]), 32'h2);
    dir_in[3:0] = 4'b0100; run(3);
    check("m1_down", 32'(dout0[3:0]), 32'h4);
    dir_in[3:0] = 4'b0000; run(4);
    dir_in[3:0] = 4'b1010; run(3);
    check("m1_simul", 32'(dout0[3:0]), 32'h8);

    // Mode 2 cancel, mode 3 raw
    mode[1:0] = 2'd2;
    dir_in[3:0] = 4'b1110; run(3); check("m2_1110", 32'(dout0[3:0]), 32'h2);
    dir_in[3:0] = 4'b1001; run(3); check("m2_1001", 32'(dout0[3:0]), 32'h9);
    dir_in[3:0] = 4'b1111; run(3); check("m2_1111", 32'(dout0[3:0]), 32'h0);
    mode[1:0] = 2'd3; run(3);      check("m3_1111", 32'(dout0[3:0]), 32'hf);

    // Rotation
    rotate = 2'd1; dir_in[3:0] = 4'b0010; run(3); check("rot1_left", 32'(dout0[3:0]), 32'h8);
    rotate = 2'd3; run(3);                        check("rot3_left", 32'(dout0[3:0]), 32'h4);
    rotate = 2'd2; dir_in[3:0] = 4'b1000; run(3); check("rot2_up",   32'(dout0[3:0]), 32'h4);
    rotate = 2'd0;

    // Debounce on the DEB_CYCLES=4 instance: short pulse, bounce, then a real hold
    dir_in[3:0] = 4'b0000; run(40);
    check("deb_idle", 32'(dout4[3:0]), 32'h0);
    dir_in[3:0] = 4'b0001; run(12); dir_in[3:0] = 4'b0000; run(20);
    check("deb_glitch", 32'(dout4[3:0]), 32'h0);
    dir_in[3:0] = 4'b0001; run(12); dir_in[3:0] = 4'b0000; run(4);
    dir_in[3:0] = 4'b0001; run(12); dir_in[3:0] = 4'b0000; run(20);
    check("deb_bounce", 32'(dout4[3:0]), 32'h0);
    dir_in[3:0] = 4'b0001; run(24);
    check("deb_hold", 32'(dout4[3:0]), 32'h1);
    dir_in[3:0] = 4'b0000; run(24);

    // Reset mid-hold in mode 1
    mode = 4'b0101; dir_in[3:0] = 4'b0100; run(10);
    reset = 1'b1; run(1);
    check("rst_mid_dout", 32'(dout0), 32'h0);
    check("rst_mid_chg",  32'(chg0),  32'h0);
    reset = 1'b0; run(3);
    check("rst_rel_dout", 32'(dout0[3:0]), 32'h4);
    check("rst_rel_chg",  32'(chg0[0]), 32'h1);
    run(1);
    check("rst_rel_chg1", 32'(chg0[0]), 32'h0);

    // Player isolation: player 1 churns, player 0 holds right in mode 0
    mode = 4'b0000; dir_in = 8'h01; run(4);
    for (int i = 0; i < 50; i++) begin
      dir_in[7:4] = 4'($urandom);
      mode[3:2]   = 2'($urandom);
      run(1);
      check("iso_dout", 32'(dout0[3:0]), 32'h1);
      check("iso_chg",  32'(chg0[0]), 32'h0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(3) == 0) dir_in[3:0] = 4'($urandom);
      if ($urandom_range(3) == 0) dir_in[7:4] = 4'($urandom);
      if ($urandom_range(40) == 0) mode = 4'($urandom);
      if ($urandom_range(80) == 0) rotate = 2'($urandom);
      reset = ($urandom_range(150) == 0);
      run(1);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
